step_dir_decoder: RTL

- Receive-side counterpart of the stepper pulse generator.
- Decodes an external step/dir pulse stream into a signed position, a pulse count, and the last measured period and pulse width.
- Rejects glitch pulses.
- Used for loop-back checking of the drive outputs and for monitoring external step sources.
- Register readout is over the same Avalon-MM slave style (avs_s0_*) as the rest of the drive subsystem.

---
 rtl/step_dir_decoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: decodes an external step/dir stream into position, pulse count, last period and width.
// Define STEP_DIR_PERIOD_AVG_EN to add a 4-sample last_period average readable at address 8.
module step_dir_decoder #(
    parameter int SIZE     = 16,
    parameter int POS_W    = 32,
    parameter int MIN_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic [7:0]  avs_s0_address,
    input  logic [31:0] avs_s0_writedata,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    output logic        pulse_seen,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

    localparam logic [SIZE-1:0]  CNT_MAX    = '1;
    localparam logic [SIZE-1:0]  CNT_ONE    = SIZE'(1);
    localparam logic [SIZE-1:0]  MIN_HIGH_C = SIZE'(MIN_HIGH);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

    function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // The sync chain has no reset so a step held high across reset is not mistaken for a fresh rising edge.
    logic step_s1, step_s2, step_d;
    logic dir_s1, dir_s;
    logic rise, fall;

    always_ff @(posedge clk) begin
        step_s1 <= step_in;
        step_s2 <= step_s1;
        step_d  <= step_s2;
        dir_s1  <= dir_in;
        dir_s   <= dir_s1;
    end

    assign rise = step_s2 & ~step_d;
    assign fall = ~step_s2 & step_d;

    state_t state, state_next;
    logic   start_pulse, end_pulse, expire;
    logic   accept, reject;

    logic [SIZE-1:0] period_cnt;
    logic [SIZE-1:0] high_cnt;
    logic [SIZE-1:0] width_next;
    logic [SIZE-1:0] rise_period;
    logic            dir_lat;
    logic            has_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (rise) state_next = HIGH;
            LOW: begin
                if (period_cnt == CNT_MAX) state_next = IDLE;
                else if (rise)             state_next = HIGH;
            end
            HIGH: begin
                if (period_cnt == CNT_MAX) state_next = IDLE;
                else if (fall)             state_next = LOW;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_pulse = 1'b0;
        end_pulse   = 1'b0;
        expire      = 1'b0;
        unique case (state)
            IDLE: start_pulse = rise;
            LOW: begin
                expire      = (period_cnt == CNT_MAX);
                start_pulse = rise & ~expire;
            end
            HIGH: begin
                expire    = (period_cnt == CNT_MAX);
                end_pulse = fall & ~expire;
            end
            default: ;
        endcase
    end

    // Width includes the cycle on which the fall is seen, so an N-cycle pin pulse measures N.
    assign width_next = sat_inc(high_cnt);
    assign accept     = end_pulse && (width_next >= MIN_HIGH_C);
    assign reject     = end_pulse && !accept;

    // period_cnt always measures cycles since the most recent accepted rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt  <= '0;
            high_cnt    <= '0;
            rise_period <= '0;
            dir_lat     <= 1'b0;
            has_prev    <= 1'b0;
            timeout     <= 1'b0;
            pulse_seen  <= 1'b0;
        end else begin
            pulse_seen <= accept;
            if (state == IDLE) begin
                if (start_pulse) period_cnt <= '0;
            end else if (accept) begin
                period_cnt <= width_next;
            end else if (!expire) begin
                period_cnt <= sat_inc(period_cnt);
            end

            if (start_pulse) begin
                high_cnt    <= '0;
                rise_period <= sat_inc(period_cnt);
                dir_lat     <= dir_s;
            end else if (state == HIGH) begin
                high_cnt <= width_next;
            end

            if (expire) begin
                timeout  <= 1'b1;
                has_prev <= 1'b0;
            end else if (accept) begin
                timeout  <= 1'b0;
                has_prev <= 1'b1;
            end
        end
    end

    logic wr_en, rd_en, wr_ctrl, clr_pos, clr_glitch, clr_err, preset, bad_wr;

    assign wr_en      = avs_s0_write;
    assign rd_en      = avs_s0_read & ~avs_s0_write;
    assign wr_ctrl    = wr_en && (avs_s0_address == 8'd0);
    assign clr_pos    = wr_ctrl && avs_s0_writedata[0];
    assign clr_glitch = wr_ctrl && avs_s0_writedata[1];
    assign clr_err    = wr_ctrl && avs_s0_writedata[3];
    assign preset     = wr_en && (avs_s0_address == 8'd7);
    assign bad_wr     = wr_en && (avs_s0_address != 8'd0) && (avs_s0_address != 8'd7);

    logic             count_en;
    logic             write_addr_err;
    logic [POS_W-1:0] position;
    logic [POS_W-1:0] pulse_count;
    logic [SIZE-1:0]  last_period;
    logic [SIZE-1:0]  last_width;
    logic [7:0]       glitch_cnt;
    logic             count_upd;
    logic             period_upd;

    assign count_upd  = accept && count_en;
    assign period_upd = count_upd && has_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_en       <= 1'b1;
            write_addr_err <= 1'b0;
            position       <= '0;
            pulse_count    <= '0;
            last_period    <= '0;
            last_width     <= '0;
            glitch_cnt     <= '0;
        end else begin
            if (wr_ctrl) count_en <= avs_s0_writedata[2];

            if (clr_err)     write_addr_err <= 1'b0;
            else if (bad_wr) write_addr_err <= 1'b1;

            // Clear beats preset, preset beats the pulse.
            if (clr_pos)        position <= '0;
            else if (preset)    position <= avs_s0_writedata[POS_W-1:0];
            else if (count_upd) position <= dir_lat ? position + POS_ONE : position - POS_ONE;

            if (clr_pos)        pulse_count <= '0;
            else if (count_upd) pulse_count <= pulse_count + POS_ONE;

            if (count_upd)  last_width  <= width_next;
            if (period_upd) last_period <= rise_period;

            if (clr_glitch)                        glitch_cnt <= '0;
            else if (reject && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    logic [31:0] period_avg;

`ifdef STEP_DIR_PERIOD_AVG_EN
    localparam int SUM_W = SIZE + 2;
    logic [SIZE-1:0]  per_hist [4];
    logic [SUM_W-1:0] per_sum;

    always_ff @(posedge clk) begin
        if (rst || clr_pos) begin
            for (int i = 0; i < 4; i++) per_hist[i] <= '0;
        end else if (period_upd) begin
            per_hist[0] <= rise_period;
            for (int i = 1; i < 4; i++) per_hist[i] <= per_hist[i-1];
        end
    end

    assign per_sum    = SUM_W'(per_hist[0]) + SUM_W'(per_hist[1])
                      + SUM_W'(per_hist[2]) + SUM_W'(per_hist[3]);
    assign period_avg = 32'(per_sum >> 2);
`else
    assign period_avg = '0;
`endif

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (avs_s0_address)
            8'd0:    rd_mux = {29'd0, count_en, 2'b00};
            8'd1:    rd_mux = 32'(position);
            8'd2:    rd_mux = 32'(last_period);
            8'd3:    rd_mux = 32'(last_width);
            8'd4:    rd_mux = 32'(pulse_count);
            8'd5:    rd_mux = {24'd0, glitch_cnt};
            8'd6:    rd_mux = {27'd0, write_addr_err, dir_s, timeout, state};
            8'd8:    rd_mux = period_avg;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avs_s0_readdata <= '0;
        end else if (rd_en) begin
            avs_s0_readdata <= rd_mux;
        end
    end

endmodule
